noc_input_fifo: RTL and testbench

- Receive side of the router link handshake. An upstream router's output arbiter drives RTS; this block answers with a one-cycle CTS pulse.
- Buffers incoming flits in a small FIFO.
- The FIFO is drained by the local output-port arbiters through their one-hot grant lines.
- One instance sits behind each router input port (N/E/W/S/L).

---
 rtl/noc_pkg.sv | 21 ++
 rtl/noc_fifo_mem.sv | 31 +++
 rtl/noc_input_fifo.sv | 76 +++++++
 tb/tb_noc_input_fifo.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/noc_pkg.sv
// Shared NoC router definitions: port indices (also the arbiter Xbar_sel bit order)
// and the flit type used by the router data path.
package noc_pkg;

  localparam int NUM_PORTS = 5;

  localparam int PORT_N = 0;
  localparam int PORT_E = 1;
  localparam int PORT_W = 2;
  localparam int PORT_S = 3;
  localparam int PORT_L = 4;

  localparam int FLIT_W = 32;
  typedef logic [FLIT_W-1:0] flit_t;

  // True when more than one grant line is asserted.
  function automatic logic multi_hot(input logic [NUM_PORTS-1:0] v);
    return (v & (v - 1'b1)) != '0;
  endfunction

endpackage

// File: rtl/noc_fifo_mem.sv
// Flit storage for the input FIFO: DEPTH x DATA_WIDTH registers,
// synchronous write and clear, asynchronous read.
module noc_fifo_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                     clk,
  input  logic                     clr,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_WIDTH-1:0]    wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_WIDTH-1:0]    rdata
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (clr)
        mem[i] <= '0;
      else if (we && (waddr == AW'(i)))
        mem[i] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/noc_input_fifo.sv
// Router input port: RTS/CTS receive handshake with a one-cycle CTS pulse per flit,
// a small flit FIFO drained by one-hot output-arbiter grants, and sticky error flags.
module noc_input_fifo
  import noc_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] RX,
  input  logic                  DRTS,
  input  logic [NUM_PORTS-1:0]  read_en,
  output logic                  CTS,
  output logic [DATA_WIDTH-1:0] Data_out,
  output logic                  empty,
  output logic                  full,
  output logic                  err_underflow,
  output logic                  err_multi_read
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [PW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count;
  logic          wr, rd, rd_req;

  // A flit is taken only while CTS is low, so DRTS still high during the
  // CTS cycle cannot double-write; this also sets the 2-cycle minimum spacing.
  assign wr     = DRTS & ~CTS & ~full;
  assign rd_req = |read_en;
  assign rd     = rd_req & ~empty;

  assign empty = (count == '0);
  assign full  = (count == CW'(DEPTH));

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      count          <= '0;
      CTS            <= 1'b0;
      err_underflow  <= 1'b0;
      err_multi_read <= 1'b0;
    end else begin
      CTS <= wr;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      case ({wr, rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (rd_req && empty)     err_underflow  <= 1'b1;
      if (multi_hot(read_en))  err_multi_read <= 1'b1;
    end
  end

  noc_fifo_mem #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH)
  ) u_mem (
    .clk   (clk),
    .clr   (rst),
    .we    (wr),
    .waddr (wr_ptr),
    .wdata (RX),
    .raddr (rd_ptr),
    .rdata (Data_out)
  );

  a_cts_pulse: assert property (@(posedge clk) disable iff (rst) CTS |=> !CTS);
  a_count_rng: assert property (@(posedge clk) disable iff (rst) count <= CW'(DEPTH));

endmodule

// File: tb/tb_noc_input_fifo.sv
// Randomized and directed checks of noc_input_fifo against a queue-based reference model.
module tb_noc_input_fifo;
  import noc_pkg::*;

  localparam int DEPTH = 4;

  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  flit_t                rx = '0;
  logic                 drts = 1'b0;
  logic [NUM_PORTS-1:0] read_en = '0;
  logic                 cts, empty, full, err_uf, err_mr;
  flit_t                data_out;

  int vectors = 0;
  int miscompares = 0;

  // reference model
  flit_t q[$];
  bit    m_cts, m_uf, m_mr, m_clean;

  noc_input_fifo #(.DATA_WIDTH(FLIT_W), .DEPTH(DEPTH)) dut (
    .clk            (clk),
    .rst            (rst),
    .RX             (rx),
    .DRTS           (drts),
    .read_en        (read_en),
    .CTS            (cts),
    .Data_out       (data_out),
    .empty          (empty),
    .full           (full),
    .err_underflow  (err_uf),
    .err_multi_read (err_mr)
  );

  always #5 clk = ~clk;

  // Advance the model by one edge using the inputs being applied, then clock the DUT.
  task automatic step();
    bit w, r;
    if (rst) begin
      q.delete();
      m_cts = 0; m_uf = 0; m_mr = 0; m_clean = 1;
    end else begin
      w = drts && !m_cts && (q.size() < DEPTH);
      r = (read_en != '0) && (q.size() != 0);
      if ((read_en != '0) && (q.size() == 0)) m_uf = 1;
      if ($countones(read_en) > 1) m_mr = 1;
      if (r) void'(q.pop_front());
      if (w) begin q.push_back(rx); m_clean = 0; end
      m_cts = w;
    end
    @(posedge clk); #1;
  endtask

  // Upstream sender: hold RTS until CTS is seen, keep it high through the CTS cycle, then drop.
  task automatic send_flit(input flit_t d, output int wait_cyc);
    bit seen = 0;
    wait_cyc = 0;
    rx = d; drts = 1'b1;
    while (!seen && wait_cyc < 20) begin
      step(); wait_cyc++;
      if (cts === 1'b1) seen = 1;
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL send_timeout: CTS never seen for flit %h", d);
    end
    step();
    vectors++;
    if (cts !== 1'b0) begin
      miscompares++;
      $display("FAIL cts_width: CTS=%b one cycle after pulse, required 0", cts);
    end
    drts = 1'b0;
  endtask

  task automatic apply_reset();
    rst = 1'b1; drts = 1'b0; read_en = '0;
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; drts = 1'b0; read_en = '0;
    step(); step();
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      vectors += 4;
      if (cts !== 1'b0)   begin miscompares++; $display("FAIL reset_cts: got %b required 0", cts); end
      if (empty !== 1'b1) begin miscompares++; $display("FAIL reset_empty: got %b required 1", empty); end
      if (full !== 1'b0)  begin miscompares++; $display("FAIL reset_full: got %b required 0", full); end
      if (data_out !== '0) begin miscompares++; $display("FAIL reset_data: got %h required 0", data_out); end
      step();
    end
  endtask

  task automatic test_single_flit();
    int w, pulses = 0;
    rx = 32'hA5A5_0001; drts = 1'b1;
    for (int i = 0; i < 6; i++) begin
      step();
      if (cts === 1'b1) pulses++;
      if (i > 0) drts = 1'b0;
    end
    drts = 1'b0;
    vectors += 3;
    if (pulses != 1)    begin miscompares++; $display("FAIL single_cts_pulses: got %0d required 1", pulses); end
    if (empty !== 1'b0) begin miscompares++; $display("FAIL single_empty: got %b required 0", empty); end
    if (data_out !== 32'hA5A5_0001)
      begin miscompares++; $display("FAIL single_data: got %h required a5a50001", data_out); end
    read_en = 5'b00001; step(); read_en = '0;
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL single_pop_empty: got %b required 1", empty); end
    w = 0;
  endtask

  task automatic test_fill();
    int w;
    for (int i = 1; i <= 4; i++) begin
      send_flit(flit_t'(i), w);
      vectors++;
      if (w != 1) begin miscompares++; $display("FAIL fill_spacing[%0d]: wait %0d cycles required 1", i, w); end
    end
    vectors++;
    if (full !== 1'b1) begin miscompares++; $display("FAIL fill_full: got %b required 1", full); end
    rx = 32'd5; drts = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      vectors++;
      if (cts !== 1'b0 || full !== 1'b1)
        begin miscompares++; $display("FAIL fill_stall: CTS=%b full=%b required 0/1", cts, full); end
    end
    vectors++;
    if (data_out !== 32'd1) begin miscompares++; $display("FAIL fill_head: got %h required 1", data_out); end
    read_en = 5'b00100; step(); read_en = '0;
    vectors++;
    if (cts !== 1'b0 || full !== 1'b0)
      begin miscompares++; $display("FAIL fill_read_refuse: CTS=%b full=%b required 0/0", cts, full); end
    step();
    vectors++;
    if (cts !== 1'b1 || full !== 1'b1)
      begin miscompares++; $display("FAIL fill_resume: CTS=%b full=%b required 1/1", cts, full); end
    step(); drts = 1'b0;
    for (int i = 2; i <= 5; i++) begin
      vectors++;
      if (data_out !== flit_t'(i)) begin miscompares++; $display("FAIL drain[%0d]: got %h required %h", i, data_out, i); end
      read_en = 5'b00001; step(); read_en = '0;
    end
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL drain_empty: got %b required 1", empty); end
  endtask

  task automatic test_simul_rw();
    int w;
    flit_t exp;
    send_flit(flit_t'($urandom), w);
    send_flit(flit_t'($urandom), w);
    for (int i = 0; i < 10; i++) begin
      rx = flit_t'($urandom); drts = 1'b1; read_en = 5'b01000;
      step();
      read_en = '0;
      vectors += 2;
      if (cts !== 1'b1 || empty !== 1'b0 || full !== 1'b0)
        begin miscompares++; $display("FAIL simul_flags[%0d]: CTS=%b empty=%b full=%b required 1/0/0", i, cts, empty, full); end
      exp = q[0];
      if (data_out !== exp) begin miscompares++; $display("FAIL simul_data[%0d]: got %h required %h", i, data_out, exp); end
      step(); drts = 1'b0;
    end
    for (int i = 0; i < 2; i++) begin
      exp = q[0];
      vectors++;
      if (data_out !== exp) begin miscompares++; $display("FAIL simul_drain[%0d]: got %h required %h", i, data_out, exp); end
      read_en = 5'b10000; step(); read_en = '0;
    end
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL simul_count: empty=%b after 2 pops, required 1", empty); end
  endtask

  task automatic test_errors();
    int w;
    apply_reset();
    read_en = 5'b10000; step(); read_en = '0;
    step(); step();
    vectors += 3;
    if (err_uf !== 1'b1) begin miscompares++; $display("FAIL underflow_flag: got %b required 1", err_uf); end
    if (empty !== 1'b1)  begin miscompares++; $display("FAIL underflow_empty: got %b required 1", empty); end
    if (err_mr !== 1'b0) begin miscompares++; $display("FAIL underflow_mr: got %b required 0", err_mr); end
    send_flit(32'h1111_0000, w);
    send_flit(32'h2222_0000, w);
    vectors++;
    if (data_out !== 32'h1111_0000)
      begin miscompares++; $display("FAIL underflow_ptr: got %h required 11110000", data_out); end
    read_en = 5'b00011; step(); read_en = '0;
    vectors += 3;
    if (err_mr !== 1'b1) begin miscompares++; $display("FAIL multi_flag: got %b required 1", err_mr); end
    if (data_out !== 32'h2222_0000)
      begin miscompares++; $display("FAIL multi_pop: got %h required 22220000", data_out); end
    if (empty !== 1'b0 || err_uf !== 1'b1)
      begin miscompares++; $display("FAIL multi_state: empty=%b uf=%b required 0/1", empty, err_uf); end
    read_en = 5'b00001; step(); read_en = '0;
    vectors++;
    if (empty !== 1'b1) begin miscompares++; $display("FAIL multi_single_pop: empty=%b required 1", empty); end
  endtask

  task automatic test_random();
    bit drop = 0;
    int r;
    flit_t exp;
    apply_reset();
    for (int i = 0; i < 400; i++) begin
      r = $urandom_range(0, 9);
      if (r < 5)      read_en = '0;
      else if (r < 9) read_en = NUM_PORTS'(1 << $urandom_range(0, NUM_PORTS-1));
      else            read_en = NUM_PORTS'($urandom);
      step();
      vectors += 5;
      if (cts !== m_cts) begin miscompares++; $display("FAIL rand_cts[%0d]: got %b required %b", i, cts, m_cts); end
      if (empty !== (q.size() == 0))
        begin miscompares++; $display("FAIL rand_empty[%0d]: got %b required %b", i, empty, q.size() == 0); end
      if (full !== (q.size() == DEPTH))
        begin miscompares++; $display("FAIL rand_full[%0d]: got %b required %b", i, full, q.size() == DEPTH); end
      if (err_uf !== m_uf || err_mr !== m_mr)
        begin miscompares++; $display("FAIL rand_err[%0d]: got %b%b required %b%b", i, err_uf, err_mr, m_uf, m_mr); end
      if (q.size() != 0 || m_clean) begin
        exp = (q.size() != 0) ? q[0] : '0;
        if (data_out !== exp) begin miscompares++; $display("FAIL rand_data[%0d]: got %h required %h", i, data_out, exp); end
      end
      if (drop) begin drts = 1'b0; drop = 0; end
      else if (cts === 1'b1) drop = 1;
      else if (!drts && $urandom_range(0, 1) == 1) begin drts = 1'b1; rx = flit_t'($urandom); end
    end
    drts = 1'b0; read_en = '0;
  endtask

  task automatic test_reset_mid();
    int w;
    apply_reset();
    read_en = 5'b00110; step(); read_en = '0;
    for (int i = 0; i < 3; i++) send_flit(flit_t'(32'hC0DE_0000 + i), w);
    rx = 32'hDEAD_BEEF; drts = 1'b1;
    step();
    vectors++;
    if (cts !== 1'b1) begin miscompares++; $display("FAIL mid_precond_cts: got %b required 1", cts); end
    rst = 1'b1; step(); rst = 1'b0; drts = 1'b0;
    vectors += 5;
    if (cts !== 1'b0)    begin miscompares++; $display("FAIL mid_cts: got %b required 0", cts); end
    if (empty !== 1'b1)  begin miscompares++; $display("FAIL mid_empty: got %b required 1", empty); end
    if (full !== 1'b0)   begin miscompares++; $display("FAIL mid_full: got %b required 0", full); end
    if (data_out !== '0) begin miscompares++; $display("FAIL mid_data: got %h required 0", data_out); end
    if (err_uf !== 1'b0 || err_mr !== 1'b0)
      begin miscompares++; $display("FAIL mid_err: got %b%b required 00", err_uf, err_mr); end
  endtask

  initial begin
    test_reset();
    test_single_flit();
    test_fill();
    test_simul_rw();
    test_errors();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
